stream_to_onchip_writer: RTL and testbench

- Upstream Avalon-MM write master for the single-port 32-bit x 16384-word on-chip memory.
- Accepts 32-bit samples on an Avalon-ST sink and buffers them in a small FIFO.
- Writes each sample to consecutive word addresses starting at a programmed base.
- Write access is gated by an arbiter grant, because the CPU shares the memory port.

---
 rtl/stream_writer_pkg.sv | 7 +
 rtl/capture_fifo.sv | 40 ++++
 rtl/stream_to_onchip_writer.sv | 93 +++++++++
 tb/tb_stream_to_onchip_writer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_writer_pkg.sv
// stream_writer_pkg: shared widths, FSM state type and byte-enable constant for the stream writer.
package stream_writer_pkg;
  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 32;
  localparam logic [3:0] BE_ALL = 4'hF;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;
endpackage

// File: rtl/capture_fifo.sv
// capture_fifo: synchronous show-ahead FIFO; head is valid whenever empty is low.
// Ports: clk, reset_n (async, active-low), push/din write, pop advances head,
// flush empties the FIFO (wins over push/pop), full/empty status, head data.
module capture_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop) rd_q <= rd_q + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= din;
  end
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head = mem_q[rd_q[AW-1:0]];
endmodule

// File: rtl/stream_to_onchip_writer.sv
// stream_to_onchip_writer: buffers Avalon-ST samples and writes them to consecutive on-chip memory words.
// Ports: clk, reset_n (async, active-low); control start/base_addr/length/abort;
// Avalon-ST sink snk_valid/snk_ready/snk_data; Avalon-MM master mem_* gated by mem_grant;
// status busy, done (one-cycle pulse), words_written.
module stream_to_onchip_writer
  import stream_writer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  input  logic              snk_valid,
  output logic              snk_ready,
  input  logic [DATA_W-1:0] snk_data,
  input  logic              mem_grant,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_written
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0] len_q, len_d, acc_q, acc_d, wr_q, wr_d;
  logic push, flush, full, empty;
  logic [DATA_W-1:0] head;
  capture_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(mem_write), .flush(flush),
    .din(snk_data), .full(full), .empty(empty), .head(head)
  );
  // full is the pre-pop state, so a full FIFO never accepts even while draining.
  assign snk_ready = (state_q == RUN) && !full && (acc_q < len_q);
  assign push = snk_valid && snk_ready;
  // abort outranks grant so nothing is committed in the abort cycle.
  assign mem_write = (state_q == RUN) && !abort && !empty && mem_grant;
  assign mem_chipselect = mem_write;
  assign mem_byteenable = mem_write ? BE_ALL : 4'h0;
  assign mem_writedata = mem_write ? head : '0;
  assign mem_address = base_q + wr_q[ADDR_W-1:0];
  assign busy = state_q == RUN;
  assign done = state_q == FINISH;
  assign words_written = wr_q;
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    len_d = len_q;
    acc_d = acc_q;
    wr_d = wr_q;
    flush = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        base_d = base_addr;
        len_d = length;
        acc_d = '0;
        wr_d = '0;
        state_d = (length == '0) ? FINISH : RUN;
      end
      RUN: if (abort) begin
        flush = 1'b1;
        state_d = IDLE;
      end else begin
        acc_d = acc_q + (ADDR_W+1)'(push);
        wr_d = wr_q + (ADDR_W+1)'(mem_write);
        if (wr_d == len_q) state_d = FINISH;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      base_q <= '0;
      len_q <= '0;
      acc_q <= '0;
      wr_q <= '0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      len_q <= len_d;
      acc_q <= acc_d;
      wr_q <= wr_d;
    end
  end
endmodule

// File: tb/tb_stream_to_onchip_writer.sv
// tb_stream_to_onchip_writer: directed scenario tests for stream_to_onchip_writer.
module tb_stream_to_onchip_writer;
  localparam int AW = 14;
  localparam int DW = 32;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0, snk_valid = 1'b0, mem_grant = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] length = '0;
  logic [DW-1:0] snk_data = '0;
  logic snk_ready, mem_chipselect, mem_write, busy, done;
  logic [AW-1:0] mem_address;
  logic [3:0] mem_byteenable;
  logic [DW-1:0] mem_writedata;
  logic [AW:0] words_written;
  int vec = 0, err = 0;

  stream_to_onchip_writer #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .length(length),
    .abort(abort), .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data),
    .mem_grant(mem_grant), .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .busy(busy), .done(done), .words_written(words_written)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [AW-1:0] b, input logic [AW:0] l);
    base_addr = b;
    length = l;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    vec++;
    if ({snk_ready, mem_chipselect, mem_write, busy, done} !== 5'b0 || mem_byteenable !== 4'h0 ||
        mem_address !== '0 || mem_writedata !== '0 || words_written !== '0) begin
      err++;
      $display("FAIL reset_outputs: ctl=%b be=%h addr=%h data=%h ww=%0d, required all zero",
               {snk_ready, mem_chipselect, mem_write, busy, done}, mem_byteenable, mem_address, mem_writedata, words_written);
    end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int sent = 0, nw = 0, nd = 0, first = -1, last = -1;
    mem_grant = 1'b1;
    launch(14'h0010, 15'd4);
    for (int c = 0; c < 12; c++) begin
      snk_valid = sent < 4;
      snk_data = 32'hA0 + sent;
      #1;
      vec++;
      if (mem_write) begin
        if (mem_address !== 14'(16 + nw) || mem_writedata !== 32'hA0 + nw || mem_byteenable !== 4'hF || !mem_chipselect) begin
          err++;
          $display("FAIL basic_write%0d: addr=%h data=%h be=%h cs=%b, required addr=%h data=%h be=f cs=1",
                   nw, mem_address, mem_writedata, mem_byteenable, mem_chipselect, 14'(16 + nw), 32'hA0 + nw);
        end
        if (first < 0) first = c;
        last = c;
        nw++;
      end else if (mem_byteenable !== 4'h0 || mem_chipselect !== 1'b0) begin
        err++;
        $display("FAIL basic_idle_be: be=%h cs=%b, required be=0 cs=0", mem_byteenable, mem_chipselect);
      end
      if (done) nd++;
      if (snk_valid && snk_ready) sent++;
      step();
    end
    snk_valid = 1'b0;
    vec++;
    if (nw != 4 || nd != 1 || sent != 4 || words_written !== 15'd4) begin
      err++;
      $display("FAIL basic_totals: writes=%0d dones=%0d accepted=%0d ww=%0d, required 4 1 4 4", nw, nd, sent, words_written);
    end
    vec++;
    if (first != 1 || last != 4) begin
      err++;
      $display("FAIL basic_timing: first=%0d last=%0d, required first=1 last=4", first, last);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [4] = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
    int sent = 0, nw = 0;
    mem_grant = 1'b1;
    launch(14'h3FFE, 15'd4);
    for (int c = 0; c < 10; c++) begin
      snk_valid = sent < 4;
      snk_data = 32'hB0 + sent;
      #1;
      if (mem_write) begin
        vec++;
        if (nw > 3 || mem_address !== exp_a[nw & 3] || mem_writedata !== 32'hB0 + nw) begin
          err++;
          $display("FAIL wrap_write%0d: addr=%h data=%h, required addr=%h data=%h", nw, mem_address, mem_writedata, exp_a[nw & 3], 32'hB0 + nw);
        end
        nw++;
      end
      if (snk_valid && snk_ready) sent++;
      step();
    end
    snk_valid = 1'b0;
    vec++;
    if (nw != 4 || words_written !== 15'd4) begin
      err++;
      $display("FAIL wrap_totals: writes=%0d ww=%0d, required 4 4", nw, words_written);
    end
  endtask

  task automatic test_stall();
    int sent = 0, nw = 0, nd = 0;
    mem_grant = 1'b0;
    launch(14'h0100, 15'd8);
    for (int c = 0; c < 10; c++) begin
      snk_valid = sent < 8;
      snk_data = 32'hC0 + sent;
      #1;
      vec++;
      if (mem_write !== 1'b0) begin
        err++;
        $display("FAIL stall_nowrite: mem_write=%b, required 0", mem_write);
      end
      if (snk_valid && snk_ready) sent++;
      step();
    end
    vec++;
    if (sent != 4 || snk_ready !== 1'b0) begin
      err++;
      $display("FAIL stall_accept: accepted=%0d ready=%b, required 4 0", sent, snk_ready);
    end
    mem_grant = 1'b1;
    for (int c = 0; c < 20; c++) begin
      snk_valid = sent < 8;
      snk_data = 32'hC0 + sent;
      #1;
      if (mem_write) begin
        vec++;
        if (mem_address !== 14'(256 + nw) || mem_writedata !== 32'hC0 + nw) begin
          err++;
          $display("FAIL stall_write%0d: addr=%h data=%h, required addr=%h data=%h", nw, mem_address, mem_writedata, 14'(256 + nw), 32'hC0 + nw);
        end
        nw++;
      end
      if (done) nd++;
      if (snk_valid && snk_ready) sent++;
      step();
    end
    snk_valid = 1'b0;
    vec++;
    if (nw != 8 || nd != 1 || sent != 8 || words_written !== 15'd8) begin
      err++;
      $display("FAIL stall_totals: writes=%0d dones=%0d accepted=%0d ww=%0d, required 8 1 8 8", nw, nd, sent, words_written);
    end
  endtask

  task automatic test_zero_and_busy_start();
    int sent = 0, nw = 0, nd = 0;
    mem_grant = 1'b1;
    launch(14'h0020, 15'd0);
    vec++;
    if (done !== 1'b1 || busy !== 1'b0 || mem_write !== 1'b0 || words_written !== '0) begin
      err++;
      $display("FAIL zero_done: done=%b busy=%b wr=%b ww=%0d, required 1 0 0 0", done, busy, mem_write, words_written);
    end
    step();
    vec++;
    if (done !== 1'b0 || mem_write !== 1'b0) begin
      err++;
      $display("FAIL zero_after: done=%b wr=%b, required 0 0", done, mem_write);
    end
    launch(14'h0200, 15'd2);
    launch(14'h0300, 15'd5);
    for (int c = 0; c < 10; c++) begin
      snk_valid = sent < 3;
      snk_data = 32'hF0 + sent;
      #1;
      if (mem_write) begin
        vec++;
        if (mem_address !== 14'(512 + nw) || mem_writedata !== 32'hF0 + nw) begin
          err++;
          $display("FAIL busy_write%0d: addr=%h data=%h, required addr=%h data=%h", nw, mem_address, mem_writedata, 14'(512 + nw), 32'hF0 + nw);
        end
        nw++;
      end
      if (done) nd++;
      if (snk_valid && snk_ready) sent++;
      step();
    end
    snk_valid = 1'b0;
    vec++;
    if (nw != 2 || nd != 1 || sent != 2 || words_written !== 15'd2) begin
      err++;
      $display("FAIL busy_totals: writes=%0d dones=%0d accepted=%0d ww=%0d, required 2 1 2 2", nw, nd, sent, words_written);
    end
  endtask

  task automatic test_abort();
    int sent = 0, nw = 0, nd = 0;
    mem_grant = 1'b1;
    launch(14'h0040, 15'd8);
    for (int c = 0; c < 10; c++) begin
      if (words_written == 15'd3) break;
      snk_valid = sent < 3;
      snk_data = 32'hD0 + sent;
      #1;
      if (snk_valid && snk_ready) sent++;
      step();
    end
    vec++;
    if (words_written !== 15'd3) begin
      err++;
      $display("FAIL abort_pre: ww=%0d, required 3", words_written);
    end
    mem_grant = 1'b0;
    for (int i = 0; i < 2; i++) begin
      snk_valid = 1'b1;
      snk_data = 32'hD3 + i;
      step();
    end
    snk_valid = 1'b0;
    mem_grant = 1'b1;
    abort = 1'b1;
    #1;
    vec++;
    if (mem_write !== 1'b0 || mem_chipselect !== 1'b0) begin
      err++;
      $display("FAIL abort_cycle_write: wr=%b cs=%b, required 0 0", mem_write, mem_chipselect);
    end
    step();
    abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      vec++;
      if (busy !== 1'b0 || done !== 1'b0 || mem_write !== 1'b0 || words_written !== 15'd3) begin
        err++;
        $display("FAIL abort_idle: busy=%b done=%b wr=%b ww=%0d, required 0 0 0 3", busy, done, mem_write, words_written);
      end
      step();
    end
    sent = 0;
    launch(14'h0080, 15'd2);
    for (int c = 0; c < 8; c++) begin
      snk_valid = sent < 2;
      snk_data = 32'hE0 + sent;
      #1;
      if (mem_write) begin
        vec++;
        if (mem_address !== 14'(128 + nw) || mem_writedata !== 32'hE0 + nw) begin
          err++;
          $display("FAIL abort_restart%0d: addr=%h data=%h, required addr=%h data=%h", nw, mem_address, mem_writedata, 14'(128 + nw), 32'hE0 + nw);
        end
        nw++;
      end
      if (done) nd++;
      if (snk_valid && snk_ready) sent++;
      step();
    end
    snk_valid = 1'b0;
    vec++;
    if (nw != 2 || nd != 1 || words_written !== 15'd2) begin
      err++;
      $display("FAIL abort_restart_totals: writes=%0d dones=%0d ww=%0d, required 2 1 2", nw, nd, words_written);
    end
  endtask

  task automatic test_reset_mid_run();
    mem_grant = 1'b0;
    launch(14'h0500, 15'd4);
    for (int i = 0; i < 2; i++) begin
      snk_valid = 1'b1;
      snk_data = 32'h50 + i;
      step();
    end
    snk_valid = 1'b0;
    mem_grant = 1'b1;
    #1;
    vec++;
    if (mem_write !== 1'b1 || mem_writedata !== 32'h50) begin
      err++;
      $display("FAIL rstmid_pre: wr=%b data=%h, required 1 00000050", mem_write, mem_writedata);
    end
    reset_n = 1'b0;
    #1;
    vec++;
    if ({snk_ready, mem_chipselect, mem_write, busy, done} !== 5'b0 || mem_byteenable !== 4'h0 ||
        mem_address !== '0 || mem_writedata !== '0 || words_written !== '0) begin
      err++;
      $display("FAIL rstmid_outputs: ctl=%b be=%h addr=%h data=%h ww=%0d, required all zero",
               {snk_ready, mem_chipselect, mem_write, busy, done}, mem_byteenable, mem_address, mem_writedata, words_written);
    end
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      vec++;
      if (mem_write !== 1'b0 || busy !== 1'b0 || words_written !== '0) begin
        err++;
        $display("FAIL rstmid_after: wr=%b busy=%b ww=%0d, required 0 0 0", mem_write, busy, words_written);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_zero_and_busy_start();
    test_abort();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
